corr_frame_sched: RTL and testbench
===================================

# corr_frame_sched

Readout scheduler that shares one byte-wide UART transmit path among `NUM_CH` correlator channel words. On a frame tick it snapshots every channel word, then streams them as uppercase ASCII hex (MSN first), comma-separated, with a CR terminating the frame. It sits between the correlator accumulators and the UART byte transmitter. It owns all sequencing so that channels never contend for the line.

## Interface
- `NUM_CH`, 4, number of channel words per frame (≥1)
- `RESOLUTION`, 32, bits per channel word (multiple of 4)
- `NIBBLES`, `RESOLUTION/4`, derived; do not override

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  permits starting a new frame; does not abort a frame in progress
- `frame_tick`  in  1  one-cycle request to capture and send a frame
- `ch_data`  in  `NUM_CH*RESOLUTION`  channel c at `[c*RESOLUTION +: RESOLUTION]`
- `tx_data`  out  8  ASCII byte to UART
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  UART accepts the byte on an edge where `tx_valid && tx_ready`
- `busy`  out  1  frame in progress
- `drop_count`  out  8  saturating count of dropped frame ticks

## Operation
- States: IDLE, DIGIT, SEP.
- IDLE: on `frame_tick && enable`:
  - latch all of `ch_data` into the snapshot register
  - set ch=0, nib=NIBBLES-1
  - go to DIGIT
- DIGIT: present the hex of snapshot ch nibble nib.
  - Encoding: n<10 → 0x30+n; n≥10 → 0x41+(n-10).
  - On accept: if nib=0, go to SEP; else nib−1.
- SEP: present 0x2C if ch<NUM_CH-1, else 0x0D.
  - On accept, if not the last channel: ch+1, nib=NIBBLES-1, go to DIGIT.
  - On accept, if the last channel: go to IDLE.
- Frame length: `NUM_CH*(NIBBLES+1)` bytes. Defaults give 36 bytes. Example: ch0=0x12AB00FF → "12AB00FF,".
- `frame_tick` while busy is dropped and `drop_count` increments, saturating at 255.
  - Exception: a tick on the same edge as acceptance of the final CR is not dropped. It starts a new frame as if in IDLE, provided `enable` is high.
- `frame_tick` with `enable` low in IDLE is ignored and not counted.
- Deasserting `enable` mid-frame has no effect; the frame completes.
- Snapshot is stable for the whole frame; `ch_data` changes after capture are not seen.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `busy`=0, `drop_count`=0, state IDLE.
  - Reset is asynchronous and takes effect mid-frame immediately; no partial byte is retained.
- `tx_data`/`tx_valid` come straight from registers; no combinational path from `tx_ready`.
- Capture at edge k: `busy` and `tx_valid` are high after edge k, first byte = MSN of ch0.
- Byte handshake:
  - The byte transfers on an edge with valid && ready.
  - The next byte is presented after that same edge, so back-to-back acceptance is possible with no bubble.
  - `tx_data` must hold stable while `tx_valid && !tx_ready`.
- `busy` and `tx_valid` fall after the edge that accepts the final CR, unless a chained frame starts on that edge. In that case both stay high and the next byte is ch0 MSN of the new snapshot.
- Minimum frame duration: `NUM_CH*(NIBBLES+1)` cycles with `tx_ready` held high.

## Structure
- Shared package `corr_uart_pkg`:
  - ASCII constants: CR 0x0D, COMMA 0x2C, ZERO 0x30, UPPER_A 0x41
  - state enum (IDLE, DIGIT, SEP)
  - function `hex_ascii(nibble)` → 8-bit byte
- No sub-module. Snapshot register, counters and FSM live in one module, and encoding uses the package function.
- Counter widths: ch is `$clog2(NUM_CH)` bits (min 1); nib is `$clog2(NIBBLES)` bits (min 1).

## Test plan
- Defaults, `tx_ready`=1, ch0..3 = 0x12AB00FF, 0xFFFFFFFF, 0x00000000, 0xDEADBEEF; one tick → exactly 36 bytes "12AB00FF,FFFFFFFF,00000000,DEADBEEF\r". `busy` is high for 36 cycles and `drop_count`=0.
- Random `tx_ready` stalls (50%) on the same frame → identical byte stream; `tx_data` stable during every stall; `ch_data` changed after capture is not reflected.
- Ticks on frame cycles 5, 10 and 20 → all three ignored, `drop_count`=3. A tick coincident with CR acceptance → new frame starts with no idle cycle, `drop_count` unchanged.
- Frame ticks while `drop_count`=255 (preloaded by 255 drops) → `drop_count` stays 255. A tick with `enable`=0 in IDLE → no output, count unchanged.
- `rst_n` asserted asynchronously mid-ch2 → `tx_valid`/`busy` drop before the next edge and `drop_count`=0. After release plus a tick → a complete fresh frame starting with ch0.
- `NUM_CH`=1, `RESOLUTION`=8, data 0xA5 → "A5\r" (3 bytes), no comma emitted.

Source files
------------

// File: rtl/corr_uart_pkg.sv
// Shared definitions for the correlator readout path: ASCII constants,
// scheduler state encoding and the nibble-to-hex encoder.
package corr_uart_pkg;

   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] COMMA   = 8'h2C;
   localparam logic [7:0] ZERO    = 8'h30;
   localparam logic [7:0] UPPER_A = 8'h41;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIGIT = 2'd1,
      SEP   = 2'd2
   } state_t;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
      if (nibble < 4'd10)
         return ZERO + {4'h0, nibble};
      else
         return UPPER_A + {4'h0, nibble} - 8'd10;
   endfunction

endpackage

// File: rtl/corr_frame_sched.sv
// Frame readout scheduler: snapshots all channel words on a frame tick and
// streams them as comma-separated uppercase hex over a byte handshake, CR-terminated.
module corr_frame_sched
   import corr_uart_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int RESOLUTION = 32,
   localparam int NIBBLES   = RESOLUTION / 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         frame_tick,
   input  logic [NUM_CH*RESOLUTION-1:0] ch_data,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         busy,
   output logic [7:0]                   drop_count
);

   localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
   localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [NIB_W-1:0] NIB_MAX = NIB_W'(NIBBLES - 1);

   state_t                         state_reg, state_next;
   logic [NUM_CH*RESOLUTION-1:0]   snap_reg, snap_next;
   logic [CH_W-1:0]                ch_reg, ch_next;
   logic [NIB_W-1:0]               nib_reg, nib_next;
   logic [7:0]                     drop_reg, drop_next;
   logic [7:0]                     tx_data_reg, tx_data_next;
   logic                           tx_valid_reg, tx_valid_next;

   logic accept;
   logic last_ch;
   logic start;
   logic drop_inc;
   int   bit_idx;

   assign accept  = tx_valid_reg && tx_ready;
   assign last_ch = (ch_reg == LAST_CH);

   always_comb begin
      state_next    = state_reg;
      snap_next     = snap_reg;
      ch_next       = ch_reg;
      nib_next      = nib_reg;
      drop_next     = drop_reg;
      tx_data_next  = 8'h00;
      tx_valid_next = 1'b0;
      start         = 1'b0;
      drop_inc      = 1'b0;
      bit_idx       = 0;

      case (state_reg)
         IDLE: begin
            if (frame_tick && enable)
               start = 1'b1;
         end
         DIGIT: begin
            drop_inc = frame_tick;
            if (accept) begin
               if (nib_reg == '0)
                  state_next = SEP;
               else
                  nib_next = nib_reg - NIB_W'(1);
            end
         end
         SEP: begin
            if (accept && last_ch) begin
               // A tick landing on the final CR acceptance chains a new frame
               // instead of being dropped (or is ignored if enable is low).
               state_next = IDLE;
               if (frame_tick && enable)
                  start = 1'b1;
            end else begin
               drop_inc = frame_tick;
               if (accept) begin
                  ch_next    = ch_reg + CH_W'(1);
                  nib_next   = NIB_MAX;
                  state_next = DIGIT;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (start) begin
         snap_next  = ch_data;
         ch_next    = '0;
         nib_next   = NIB_MAX;
         state_next = DIGIT;
      end

      if (drop_inc && (drop_reg != 8'hFF))
         drop_next = drop_reg + 8'd1;

      // The byte register is loaded from next-state values so the following
      // byte is on the line right after the accepting edge.
      bit_idx = int'(ch_next) * RESOLUTION + int'(nib_next) * 4;
      case (state_next)
         DIGIT: begin
            tx_data_next  = hex_ascii(snap_next[bit_idx +: 4]);
            tx_valid_next = 1'b1;
         end
         SEP: begin
            tx_data_next  = (ch_next == LAST_CH) ? CR : COMMA;
            tx_valid_next = 1'b1;
         end
         default: begin
            tx_data_next  = 8'h00;
            tx_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         snap_reg     <= '0;
         ch_reg       <= '0;
         nib_reg      <= '0;
         drop_reg     <= 8'h00;
         tx_data_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         snap_reg     <= snap_next;
         ch_reg       <= ch_next;
         nib_reg      <= nib_next;
         drop_reg     <= drop_next;
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
      end
   end

   assign tx_data    = tx_data_reg;
   assign tx_valid   = tx_valid_reg;
   assign busy       = tx_valid_reg;
   assign drop_count = drop_reg;

endmodule

// File: tb/tb_corr_frame_sched.sv
// Directed bench for corr_frame_sched: default 4x32 instance plus a 1x8 instance.
module tb_corr_frame_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         frame_tick;
   logic [127:0] ch_data;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic [7:0]   drop_count;

   logic         s_frame_tick;
   logic [7:0]   s_ch_data;
   logic [7:0]   s_tx_data;
   logic         s_tx_valid;
   logic         s_tx_ready;
   logic         s_busy;
   logic [7:0]   s_drop_count;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] DEF_DATA = {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h12AB00FF};
   string exp_frame = "12AB00FF,FFFFFFFF,00000000,DEADBEEF\r";
   string exp_small = "A5\r";

   always #5 clk = ~clk;

   corr_frame_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .frame_tick (frame_tick),
      .ch_data    (ch_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .drop_count (drop_count)
   );

   corr_frame_sched #(.NUM_CH(1), .RESOLUTION(8)) dut_small (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .frame_tick (s_frame_tick),
      .ch_data    (s_ch_data),
      .tx_data    (s_tx_data),
      .tx_valid   (s_tx_valid),
      .tx_ready   (s_tx_ready),
      .busy       (s_busy),
      .drop_count (s_drop_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse frame_tick for one edge; returns at the negedge after that edge.
   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   // Called at the negedge after capture; consumes one frame byte by byte.
   task automatic run_frame(input string exp, input bit stall,
                            input int t0, input int t1, input int t2, input int t3);
      int idx = 0;
      int cyc = 0;
      bit was_stall = 1'b0;
      logic [7:0] held = 8'h00;
      while (idx < exp.len() && cyc < 4000) begin
         if (!tx_valid) begin
            check("valid_in_frame", {31'd0, tx_valid}, 32'd1);
            break;
         end
         if (was_stall) check("stall_hold", tx_data, held);
         frame_tick = (cyc == t0) || (cyc == t1) || (cyc == t2) || (cyc == t3);
         tx_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (tx_ready) begin
            check("byte", tx_data, exp[idx]);
            idx++;
            was_stall = 1'b0;
         end else begin
            held = tx_data;
            was_stall = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      frame_tick = 1'b0;
      tx_ready = 1'b1;
      check("frame_len", idx, exp.len());
      if (!stall) check("busy_cycles", cyc, exp.len());
      $display("frame bytes=%0d cycles=%0d drop_count=%0d", idx, cyc, drop_count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sidx;
      rst_n        = 1'b0;
      enable       = 1'b1;
      frame_tick   = 1'b0;
      ch_data      = DEF_DATA;
      tx_ready     = 1'b1;
      s_frame_tick = 1'b0;
      s_ch_data    = 8'hA5;
      s_tx_ready   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", tx_data, 32'h00);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_drop", drop_count, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain frame, ready held high.
      tick();
      check("start_busy", {31'd0, busy}, 32'd1);
      run_frame(exp_frame, 1'b0, -1, -1, -1, -1);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_valid", {31'd0, tx_valid}, 32'd0);
      check("drop_zero", drop_count, 32'd0);

      // Random stalls; input data changes after capture must not show.
      tick();
      ch_data = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      run_frame(exp_frame, 1'b1, -1, -1, -1, -1);
      check("stall_end_busy", {31'd0, busy}, 32'd0);
      check("stall_drop", drop_count, 32'd0);
      ch_data = DEF_DATA;

      // Ticks mid-frame are dropped; tick on final CR accept chains.
      tick();
      run_frame(exp_frame, 1'b0, 5, 10, 20, 35);
      check("chain_busy", {31'd0, busy}, 32'd1);
      check("chain_valid", {31'd0, tx_valid}, 32'd1);
      check("chain_first", tx_data, 32'h31);
      check("drop_three", drop_count, 32'd3);
      run_frame(exp_frame, 1'b0, -1, -1, -1, -1);
      check("chain_end_busy", {31'd0, busy}, 32'd0);
      check("chain_drop", drop_count, 32'd3);

      // Saturation of drop_count.
      tx_ready = 1'b0;
      tick();
      tx_ready = 1'b0;
      for (int i = 0; i < 260; i++) begin
         frame_tick = 1'b1;
         @(negedge clk);
      end
      frame_tick = 1'b0;
      check("drop_sat", drop_count, 32'd255);
      run_frame(exp_frame, 1'b0, 2, 7, 30, -1);
      check("drop_sat_hold", drop_count, 32'd255);

      // Tick with enable low in IDLE is ignored.
      enable = 1'b0;
      tick();
      @(negedge clk);
      check("dis_busy", {31'd0, busy}, 32'd0);
      check("dis_valid", {31'd0, tx_valid}, 32'd0);
      check("dis_drop", drop_count, 32'd255);
      enable = 1'b1;

      // Asynchronous reset in the middle of ch2.
      tick();
      repeat (21) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, tx_valid}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_drop", drop_count, 32'd0);
      check("arst_data", tx_data, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_frame(exp_frame, 1'b0, -1, -1, -1, -1);
      check("arst_frame_end", {31'd0, busy}, 32'd0);

      // Single 8-bit channel instance.
      @(negedge clk);
      s_frame_tick = 1'b1;
      @(negedge clk);
      s_frame_tick = 1'b0;
      sidx = 0;
      for (int i = 0; i < 10; i++) begin
         if (s_tx_valid && sidx < exp_small.len()) begin
            check("small_byte", s_tx_data, exp_small[sidx]);
            sidx++;
         end
         @(negedge clk);
      end
      check("small_len", sidx, 32'd3);
      check("small_busy", {31'd0, s_busy}, 32'd0);
      check("small_drop", s_drop_count, 32'd0);
      $display("small frame bytes=%0d", sidx);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
